reaction_timer: RTL and testbench
=================================

Name: reaction_timer

Overview:
- Produces reaction-time measurements for the high-score tracker of the reaction timer game.
- On a start request it waits a pseudo-random delay, lights the stimulus LED, then counts time units until the player presses react.
- Presents the measured time on timecount with a one-cycle result_valid strobe.
- timecount = 0 never denotes a valid time, so the high-score tracker ignores false starts by construction.

Parameters:
- TIME_W, 24, width of timecount and internal reaction counter.
- TICK_DIV, 50000, clock cycles per time unit (1 ms at 50 MHz).
- MIN_DELAY, 1000, minimum pre-stimulus delay in time units.
- RANGE_MASK, 2047, mask applied to LFSR for the random delay component; must be 2^n-1.
- SEED, 16'hACE1, nonzero 16-bit LFSR reset value.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  start button, pre-synchronised level, active-high
- react  input  1  reaction button, pre-synchronised level, active-high
- led_on  output  1  stimulus LED
- timecount  output  TIME_W  last result in time units; 0 = no valid result
- result_valid  output  1  one-cycle strobe when timecount updates
- false_start  output  1  high after react pressed before stimulus
- busy  output  1  high in WAIT or ARMED

Behaviour:
- Interface: one clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE; led_on, busy, false_start, result_valid = 0; timecount = 0.
  - LFSR = SEED; prescaler and counters = 0.
  - Reset mid-round aborts immediately; no result strobe.
- Edge detection: start_rise = start & ~start_q; react_rise likewise. Registers update every cycle in every state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, including in IDLE.
- Prescaler: counts 0..TICK_DIV-1 and asserts tick at wrap. Clears on entry to WAIT and ARMED, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - start_rise -> delay = MIN_DELAY + (lfsr & RANGE_MASK); clear false_start; go WAIT.
  - react_rise in the same cycle is ignored.
- WAIT (busy=1, led_on=0):
  - Each tick decrements delay.
  - react_rise -> FOUL: false_start=1, timecount=0, result_valid strobe.
  - On tick with delay==1 and no react_rise -> ARMED: led_on=1, count=0.
  - react_rise in the same cycle as the final tick -> FOUL (react wins).
- ARMED (busy=1, led_on=1):
  - Each tick increments count.
  - react_rise -> timecount = max(count,1), result_valid=1 next cycle, led_on=0, go DONE.
  - count reaching all-ones (timeout) -> timecount = all-ones, strobe, DONE.
  - react_rise on the saturating tick reports count before the increment.
- DONE / FOUL:
  - led_on=0, busy=0; timecount and false_start held.
  - start_rise -> new round exactly as from IDLE. timecount keeps its old value until the next result.
- Latency: react_rise seen in cycle k -> timecount and result_valid valid in cycle k+1; led_on low in k+1.
- result_valid is exactly one cycle per round; never asserted by reset.
- start_rise while busy is ignored; rounds are not restartable mid-flight.

Decomposition:
- Shared package rt_pkg:
  - state enum {IDLE, WAIT, ARMED, DONE, FOUL}
  - LFSR tap constant
  - TIME_W default, so the high-score tracker shares the width
- Sub-module tick_prescaler (parameter TICK_DIV; inputs clk, reset, clear; output tick). Natural to split out; reused by display scan logic.

Test Plan:
- Params: TIME_W=8, TICK_DIV=4, MIN_DELAY=2, RANGE_MASK=3, SEED=16'h0001.
- Reset: assert reset 3 cycles mid-ARMED -> next cycle all outputs 0, state IDLE, no result_valid.
- Normal round: start pulse, wait for led_on, press react 5 ticks (20 cycles) after led_on rises -> led_on already high within 2..5 ticks×4 cycles of start; timecount=5, single result_valid, false_start=0, busy=0.
- False start: start, press react 3 cycles later -> false_start=1, timecount=0, result_valid one cycle, led_on never asserts.
- Instant react: react rising in the same cycle led_on is first sampled high -> timecount=1 (clamped), not 0.
- Timeout: start, never press -> after led_on, 255 ticks later timecount=8'hFF, result_valid pulse, state DONE.
- Ignore/restart: start_rise during ARMED ignored (count continues); after DONE, a second round with react at 3 ticks -> timecount goes 5->3 only at the new result_valid.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer game and its high-score tracker.
package rt_pkg;

   localparam int TIME_W_DEF = 24;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {IDLE, WAIT, ARMED, DONE, FOUL} state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/reaction_timer_tick_prescaler.sv
// Free-running time-unit prescaler; tick is high for the last cycle of each TICK_DIV period.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random pre-stimulus delay, LED stimulus, reaction time measured in ticks.
module reaction_timer
   import rt_pkg::*;
#(
   parameter int          TIME_W     = TIME_W_DEF,
   parameter int          TICK_DIV   = 50000,
   parameter int          MIN_DELAY  = 1000,
   parameter int          RANGE_MASK = 2047,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              react,
   output logic              led_on,
   output logic [TIME_W-1:0] timecount,
   output logic              result_valid,
   output logic              false_start,
   output logic              busy
);

   localparam int DELAY_W = $clog2(MIN_DELAY + RANGE_MASK + 1);

   state_t              state;
   logic                start_q, react_q;
   logic [15:0]         lfsr;
   logic [DELAY_W-1:0]  delay;
   logic [DELAY_W-1:0]  delay_load;
   logic [TIME_W-1:0]   count;
   logic [TIME_W-1:0]   count_inc;
   logic                start_rise, react_rise;
   logic                tick, enter_wait, enter_armed;

   assign start_rise = start & ~start_q;
   assign react_rise = react & ~react_q;
   assign delay_load = DELAY_W'(MIN_DELAY + int'(lfsr & 16'(RANGE_MASK)));
   assign count_inc  = count + TIME_W'(1);

   // Prescaler restarts on the same edge the state changes, so phase 0 lines up with entry.
   assign enter_wait  = (state == IDLE || state == DONE || state == FOUL) && start_rise;
   assign enter_armed = (state == WAIT) && tick && !react_rise && (delay == DELAY_W'(1));

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (enter_wait | enter_armed),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      start_q <= start;
      react_q <= react;
      if (reset) begin
         state        <= IDLE;
         lfsr         <= SEED;
         delay        <= '0;
         count        <= '0;
         led_on       <= 1'b0;
         busy         <= 1'b0;
         false_start  <= 1'b0;
         result_valid <= 1'b0;
         timecount    <= '0;
      end else begin
         lfsr         <= lfsr_next(lfsr);
         result_valid <= 1'b0;
         case (state)
            IDLE, DONE, FOUL: begin
               if (start_rise) begin
                  delay       <= delay_load;
                  false_start <= 1'b0;
                  busy        <= 1'b1;
                  led_on      <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (react_rise) begin
                  false_start  <= 1'b1;
                  timecount    <= '0;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= FOUL;
               end else if (tick) begin
                  if (delay == DELAY_W'(1)) begin
                     led_on <= 1'b1;
                     count  <= '0;
                     state  <= ARMED;
                  end else begin
                     delay <= delay - DELAY_W'(1);
                  end
               end
            end
            ARMED: begin
               if (react_rise) begin
                  timecount    <= (count == '0) ? TIME_W'(1) : count;
                  result_valid <= 1'b1;
                  led_on       <= 1'b0;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else if (tick) begin
                  count <= count_inc;
                  if (&count_inc) begin
                     timecount    <= '1;
                     result_valid <= 1'b1;
                     led_on       <= 1'b0;
                     busy         <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer with small parameters (4-cycle tick, 8-bit time).
module tb_reaction_timer;

   localparam int TIME_W = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              react = 1'b0;
   logic              led_on;
   logic [TIME_W-1:0] timecount;
   logic              result_valid;
   logic              false_start;
   logic              busy;

   int n_cmp = 0;
   int n_err = 0;
   int rv_count = 0;
   int r0 = 0;
   int n = 0;
   logic led_seen = 1'b0;

   reaction_timer #(
      .TIME_W     (TIME_W),
      .TICK_DIV   (4),
      .MIN_DELAY  (2),
      .RANGE_MASK (3),
      .SEED       (16'h0001)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .react        (react),
      .led_on       (led_on),
      .timecount    (timecount),
      .result_valid (result_valid),
      .false_start  (false_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      if (result_valid) rv_count++;
      if (led_on) led_seen = 1'b1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic press();
      react = 1'b1;
      step();
      react = 1'b0;
   endtask

   task automatic wait_led(input string tag, output int cycles);
      cycles = 0;
      while (!led_on && cycles < 64) begin
         step();
         cycles++;
      end
      check(tag, 32'(led_on), 32'd1);
   endtask

   initial begin
      // reset state
      repeat (3) step();
      check("rst_led", 32'(led_on), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fs", 32'(false_start), 32'd0);
      check("rst_rv", 32'(result_valid), 32'd0);
      check("rst_tc", 32'(timecount), 32'd0);
      reset = 1'b0;
      step();
      check("rst_rv_count", 32'(rv_count), 32'd0);

      // normal round, react 20 cycles after led rises
      r0 = rv_count;
      start_pulse();
      check("norm_busy", 32'(busy), 32'd1);
      check("norm_led_early", 32'(led_on), 32'd0);
      wait_led("norm_led", n);
      check("norm_lat_mod4", 32'(n % 4), 32'd0);
      check("norm_lat_range", 32'(n >= 8 && n <= 20), 32'd1);
      repeat (20) step();
      press();
      check("norm_tc", 32'(timecount), 32'd5);
      check("norm_rv", 32'(result_valid), 32'd1);
      check("norm_led_off", 32'(led_on), 32'd0);
      check("norm_busy_off", 32'(busy), 32'd0);
      check("norm_fs", 32'(false_start), 32'd0);
      step();
      check("norm_rv_drop", 32'(result_valid), 32'd0);
      check("norm_rv_once", 32'(rv_count - r0), 32'd1);

      // false start
      r0 = rv_count;
      led_seen = 1'b0;
      start_pulse();
      repeat (2) step();
      press();
      check("foul_fs", 32'(false_start), 32'd1);
      check("foul_tc", 32'(timecount), 32'd0);
      check("foul_rv", 32'(result_valid), 32'd1);
      check("foul_busy", 32'(busy), 32'd0);
      repeat (30) step();
      check("foul_rv_once", 32'(rv_count - r0), 32'd1);
      check("foul_no_led", 32'(led_seen), 32'd0);
      check("foul_fs_held", 32'(false_start), 32'd1);

      // instant react clamps to 1
      start_pulse();
      check("inst_fs_clear", 32'(false_start), 32'd0);
      wait_led("inst_led", n);
      press();
      check("inst_tc", 32'(timecount), 32'd1);
      check("inst_rv", 32'(result_valid), 32'd1);
      step();

      // start during ARMED ignored, then a second round replaces 5 with 3
      r0 = rv_count;
      start_pulse();
      wait_led("ign_led", n);
      repeat (10) step();
      start_pulse();
      check("ign_still_armed", 32'(led_on), 32'd1);
      repeat (9) step();
      press();
      check("ign_tc", 32'(timecount), 32'd5);
      check("ign_rv", 32'(result_valid), 32'd1);
      step();
      start_pulse();
      check("rst2_tc_hold_wait", 32'(timecount), 32'd5);
      wait_led("rst2_led", n);
      check("rst2_tc_hold_armed", 32'(timecount), 32'd5);
      repeat (12) step();
      press();
      check("rst2_tc", 32'(timecount), 32'd3);
      check("rst2_rv", 32'(result_valid), 32'd1);
      check("rst2_rv_count", 32'(rv_count - r0), 32'd2);
      step();

      // timeout after 255 ticks
      start_pulse();
      wait_led("tmo_led", n);
      n = 0;
      while (!result_valid && n < 1100) begin
         step();
         n++;
      end
      check("tmo_cycles", 32'(n), 32'd1020);
      check("tmo_tc", 32'(timecount), 32'hFF);
      check("tmo_led_off", 32'(led_on), 32'd0);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_fs", 32'(false_start), 32'd0);
      step();
      check("tmo_rv_drop", 32'(result_valid), 32'd0);

      // reset mid-ARMED aborts without a result
      start_pulse();
      wait_led("rstm_led", n);
      repeat (5) step();
      r0 = rv_count;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check("rstm_led", 32'(led_on), 32'd0);
      check("rstm_busy", 32'(busy), 32'd0);
      check("rstm_tc", 32'(timecount), 32'd0);
      check("rstm_fs", 32'(false_start), 32'd0);
      step();
      press();
      repeat (3) step();
      check("rstm_idle_busy", 32'(busy), 32'd0);
      check("rstm_no_rv", 32'(rv_count - r0), 32'd0);
      check("rstm_idle_tc", 32'(timecount), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
